// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the N-way traffic-light controller.
// The WALK state only exists when PED_WALK_EN is defined.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
`ifdef PED_WALK_EN
        ,
        WALK    = 2'd3
`endif
    } state_t;

    // One-hot lamp code per approach: {red, yellow, green}
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_nway_tick_prescaler.sv
// Slow-tick prescaler: one-cycle tick strobe every TICK_DIV enabled fast_clk cycles.
module tick_prescaler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic fast_clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CNT_W = width_for(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/traffic_light_ctrl_nway.sv
// Round-robin N-direction traffic-light phase sequencer with demand skipping and green hold.
// Optional pedestrian WALK phase is built when PED_WALK_EN is defined.
module traffic_light_ctrl_nway
    import traffic_pkg::*;
#(
    parameter int NUM_DIR      = 4,
    parameter int TICK_DIV     = 1000,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10
) (
    input  logic                       fast_clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_DIR-1:0]         demand,
`ifdef PED_WALK_EN
    input  logic                       ped_req,
    output logic                       walk,
`endif
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] dir,
    output logic                       tick
);

    localparam int DIR_W = $clog2(NUM_DIR);
    localparam int CNT_W = width_for(max_of(TICK_DIV, max_of(GREEN_TICKS,
                           max_of(YELLOW_TICKS, max_of(ALLRED_TICKS, WALK_TICKS)))));

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);
    localparam logic [NUM_DIR-1:0] ONE_HOT0  = NUM_DIR'(1);

    state_t             state_q, state_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   dur_last;
    logic [NUM_DIR-1:0] red_d, yellow_d, green_d;
    logic [NUM_DIR-1:0] others;
    logic               slow_tick;
    logic               ped_pending;
    logic               walk_start;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .fast_clk (fast_clk),
        .rst      (rst),
        .en       (en),
        .tick     (slow_tick)
    );

    assign tick = slow_tick;

    // First demanding approach after cur (wrapping, cur itself last); cur+1 when nobody waits.
    function automatic logic [DIR_W-1:0] next_dir(input logic [DIR_W-1:0]   cur,
                                                  input logic [NUM_DIR-1:0] dem);
        logic [2*NUM_DIR-1:0] rot;
        logic [DIR_W-1:0]     pick;
        rot  = {dem, dem} >> (int'(cur) + 1);
        pick = DIR_W'((int'(cur) + 1) % NUM_DIR);
        for (int i = NUM_DIR - 1; i >= 0; i--) begin
            if (rot[i]) pick = DIR_W'((int'(cur) + 1 + i) % NUM_DIR);
        end
        return pick;
    endfunction

    always_comb begin
        dur_last = ALLRED_LAST;
        case (state_q)
            GREEN:   dur_last = GREEN_LAST;
            YELLOW:  dur_last = YELLOW_LAST;
`ifdef PED_WALK_EN
            WALK:    dur_last = WALK_LAST;
`endif
            default: dur_last = ALLRED_LAST;
        endcase
    end

    assign others = demand & ~(ONE_HOT0 << dir_q);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        walk_start = 1'b0;
        if (slow_tick) begin
            if (timer_q == dur_last) begin
                timer_d = '0;
                case (state_q)
                    ALL_RED: begin
`ifdef PED_WALK_EN
                        if (ped_pending) begin
                            state_d    = WALK;
                            walk_start = 1'b1;
                        end else begin
                            state_d = GREEN;
                            dir_d   = next_dir(dir_q, demand);
                        end
`else
                        state_d = GREEN;
                        dir_d   = next_dir(dir_q, demand);
`endif
                    end
                    // Hold green only when this approach is the sole one waiting
                    GREEN: begin
                        if (demand == '0 || others != '0) state_d = YELLOW;
                    end
                    YELLOW:  state_d = ALL_RED;
                    default: state_d = ALL_RED;
                endcase
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Lamps are decoded from the next state so they switch on the expiry edge itself
    always_comb begin
        lamp_t lamp;
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            lamp = LAMP_RED;
            if (dir_d == DIR_W'(i)) begin
                if (state_d == GREEN)  lamp = LAMP_GREEN;
                if (state_d == YELLOW) lamp = LAMP_YELLOW;
            end
            red_d[i]    = (lamp == LAMP_RED);
            yellow_d[i] = (lamp == LAMP_YELLOW);
            green_d[i]  = (lamp == LAMP_GREEN);
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q <= ALL_RED;
            dir_q   <= DIR_W'(NUM_DIR - 1);
            timer_q <= '0;
            red     <= '1;
            yellow  <= '0;
            green   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            red     <= red_d;
            yellow  <= yellow_d;
            green   <= green_d;
        end
    end

    assign dir = dir_q;

`ifdef PED_WALK_EN
    // A request coinciding with WALK entry is kept for the following cycle of service
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            ped_pending <= (ped_pending && !walk_start) || ped_req;
            walk        <= (state_d == WALK);
        end
    end
`else
    assign ped_pending = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl_nway.sv
// Self-checking bench for traffic_light_ctrl_nway: phase-level model plus directed scenarios.
// Ped-walk scenario runs only when PED_WALK_EN is defined.
module tb_traffic_light_ctrl_nway;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int GT = 3;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int WT = 2;

    localparam int M_AR = 0, M_GREEN = 1, M_YEL = 2, M_WALK = 3;

    logic          fast_clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [ND-1:0] demand = 4'b1111;
    logic          ped_req = 1'b0;
    logic          walk_out;
    logic [ND-1:0] red, yellow, green;
    logic [1:0]    dir;
    logic          tick;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl_nway #(
        .NUM_DIR(ND), .TICK_DIV(TD), .GREEN_TICKS(GT),
        .YELLOW_TICKS(YT), .ALLRED_TICKS(AT), .WALK_TICKS(WT)
    ) dut (
        .fast_clk (fast_clk),
        .rst      (rst),
        .en       (en),
        .demand   (demand),
`ifdef PED_WALK_EN
        .ped_req  (ped_req),
        .walk     (walk_out),
`endif
        .red      (red),
        .yellow   (yellow),
        .green    (green),
        .dir      (dir),
        .tick     (tick)
    );

`ifndef PED_WALK_EN
    assign walk_out = 1'b0;
`endif

    always #5 fast_clk = ~fast_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Phase-level model: each phase lasts duration*TD enabled cycles.
    int m_st, m_dir, m_left, m_encnt;
    bit m_ped;

    function automatic int pick_next(input int cur, input logic [ND-1:0] d);
        logic [ND-1:0] dd;
        for (int k = 1; k <= ND; k++) begin
            dd = d >> ((cur + k) % ND);
            if (dd[0]) return (cur + k) % ND;
        end
        return (cur + 1) % ND;
    endfunction

    always @(posedge fast_clk or posedge rst) begin
        bit go_walk;
        go_walk = 1'b0;
        if (rst) begin
            m_st    <= M_AR;
            m_dir   <= ND - 1;
            m_left  <= AT * TD;
            m_encnt <= 0;
            m_ped   <= 1'b0;
        end else begin
            if (en) begin
                m_encnt <= m_encnt + 1;
                if (m_left > 1) begin
                    m_left <= m_left - 1;
                end else begin
                    case (m_st)
                        M_AR: begin
                            if (m_ped) begin
                                m_st <= M_WALK; m_left <= WT * TD; go_walk = 1'b1;
                            end else begin
                                m_st <= M_GREEN; m_left <= GT * TD;
                                m_dir <= pick_next(m_dir, demand);
                            end
                        end
                        M_GREEN: begin
                            if (demand == 0 || (int'(demand) & ~(1 << m_dir)) != 0) begin
                                m_st <= M_YEL; m_left <= YT * TD;
                            end else begin
                                m_left <= GT * TD;
                            end
                        end
                        default: begin
                            m_st <= M_AR; m_left <= AT * TD;
                        end
                    endcase
                end
            end
            m_ped <= (m_ped && !go_walk) || ped_req;
        end
    end

    always @(negedge fast_clk) begin
        logic [ND-1:0] e_red, e_yel, e_grn;
        for (int i = 0; i < ND; i++) begin
            e_grn[i] = (m_st == M_GREEN) && (m_dir == i);
            e_yel[i] = (m_st == M_YEL) && (m_dir == i);
            e_red[i] = !(e_grn[i] || e_yel[i]);
        end
        check("model_red",    32'(red),    32'(e_red));
        check("model_yellow", 32'(yellow), 32'(e_yel));
        check("model_green",  32'(green),  32'(e_grn));
        check("model_dir",    32'(dir),    32'(m_dir));
        check("model_tick",   32'(tick),   32'(en && (m_encnt % TD == TD - 1)));
`ifdef PED_WALK_EN
        check("model_walk",   32'(walk_out), 32'(m_st == M_WALK));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge fast_clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("rst_red", 32'(red), 32'hF);
        check("rst_green", 32'(green), 32'h0);
        check("rst_yellow", 32'(yellow), 32'h0);
        check("rst_dir", 32'(dir), 32'd3);
        check("rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;

        // First green on the 4th edge after release, yellow 12 later, all-red 8, green[1] 4
        step(3);
        check("first_tick", 32'(tick), 32'd1);
        check("pre_green0", 32'(green), 32'h0);
        step(1);
        check("green0", 32'(green), 32'b0001);
        check("green0_dir", 32'(dir), 32'd0);
        step(11);
        check("green0_late", 32'(green), 32'b0001);
        step(1);
        check("yellow0", 32'(yellow), 32'b0001);
        step(8);
        check("allred_a", 32'(red), 32'hF);
        step(4);
        check("green1", 32'(green), 32'b0010);

        // Only approach 0 waiting: serve it, then it must be held
        demand = 4'b0001;
        step(12);
        check("yellow1", 32'(yellow), 32'b0010);
        step(12);
        check("green0_again", 32'(green), 32'b0001);
        step(36);
        check("green0_hold", 32'(green), 32'b0001);
        check("green0_hold_y", 32'(yellow), 32'b0000);

        // 1 and 2 skipped
        demand = 4'b1001;
        step(11);
        check("hold_end_green", 32'(green), 32'b0001);
        step(1);
        check("yellow0_skip", 32'(yellow), 32'b0001);
        step(12);
        check("green3", 32'(green), 32'b1000);
        check("green3_dir", 32'(dir), 32'd3);

        // Demand arriving mid-phase is acted on at the next expiry
        demand = 4'b1000;
        step(6);
        demand = 4'b1100;
        step(6);
        check("yellow3", 32'(yellow), 32'b1000);
        step(12);
        check("green2", 32'(green), 32'b0100);

        // en low 10 cycles mid-green stretches green to 22 cycles
        step(4);
        en = 1'b0;
        step(1);
        check("frozen_tick", 32'(tick), 32'd0);
        step(9);
        check("frozen_green", 32'(green), 32'b0100);
        en = 1'b1;
        step(7);
        check("stretched_green", 32'(green), 32'b0100);
        step(1);
        check("yellow2", 32'(yellow), 32'b0100);

        // Reset mid-yellow: immediate all-red, restart with green[0]
        step(3);
        rst = 1'b1;
        #1;
        check("midrst_red", 32'(red), 32'hF);
        check("midrst_green", 32'(green), 32'h0);
        check("midrst_yellow", 32'(yellow), 32'h0);
        step(1);
        demand = 4'b1111;
        rst = 1'b0;
        step(3);
        check("restart_pre", 32'(green), 32'h0);
        step(1);
        check("restart_green0", 32'(green), 32'b0001);

        // No demand at all: fixed-time fallback to dir+1
        demand = 4'b0000;
        step(12);
        check("nodemand_yellow0", 32'(yellow), 32'b0001);
        step(12);
        check("nodemand_green1", 32'(green), 32'b0010);
        check("nodemand_dir", 32'(dir), 32'd1);

`ifdef PED_WALK_EN
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(11);
        check("ped_yellow1", 32'(yellow), 32'b0010);
        step(8);
        check("ped_allred", 32'(red), 32'hF);
        check("ped_nowalk", 32'(walk_out), 32'd0);
        step(4);
        check("walk_on", 32'(walk_out), 32'd1);
        check("walk_red", 32'(red), 32'hF);
        step(7);
        check("walk_hold", 32'(walk_out), 32'd1);
        step(1);
        check("walk_off", 32'(walk_out), 32'd0);
        check("post_walk_red", 32'(red), 32'hF);
        step(4);
        check("post_walk_green2", 32'(green), 32'b0100);
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
